// File: rtl/usrt_pkg.sv
// usrt_pkg: state encodings, frame constants and small helpers shared by the
// serial transmit and receive shift registers.
package usrt_pkg;

  localparam int DATA_BITS = 8;
  localparam int BAUD_W    = 14;

  typedef logic [2:0] usrt_state_t;

  localparam usrt_state_t s_IDLE   = 3'b000;
  localparam usrt_state_t s_START  = 3'b001;
  localparam usrt_state_t s_DATA   = 3'b010;
  localparam usrt_state_t s_STOP   = 3'b011;
  localparam usrt_state_t s_FINISH = 3'b100;

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  // 2-of-3 vote used for glitch-tolerant line sampling.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// sync_ff: STAGES-deep flip-flop chain that brings an asynchronous input into
// the clock domain. Resets to 1 so an idle-high serial line looks idle.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the raw input through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= {STAGES{1'b1}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/rxshift.sv
// rxshift: UART-style receive shift register (1 start, 8 data LSB first,
// 1 stop). Bit timing comes from a clocks-per-bit count latched when the start
// bit is detected. Delivers each byte with a one-cycle o_Pready strobe.
//
// Build option RXSHIFT_MAJORITY_EN: data/stop samples and the start-bit check
// take a 2-of-3 vote over three consecutive synchronised line values.
module rxshift
  import usrt_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 i_Pclk,
  input  logic                 i_Reset,
  input  logic [BAUD_W-1:0]    i_Baud,
  input  logic                 i_Enable,
  input  logic                 i_Rx_Serial,
  output logic [DATA_BITS-1:0] o_Data,
  output logic                 o_Pready,
  output logic                 o_Frame_Err,
  output logic                 o_Busy
);

  usrt_state_t          state;
  logic [BAUD_W-1:0]    clock_count;
  logic [BAUD_W-1:0]    baud_q;
  logic [2:0]           bit_index;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 pready_q;
  logic                 frame_err_q;
  logic                 busy_q;
  // Cleared after a frame whose stop bit was low; a new start is only
  // accepted once the line has been seen high again (no re-trigger on break).
  logic                 armed_q;

  logic                 rx_s;
  logic                 sample_s;
  logic [BAUD_W-1:0]    half_m1_s;
  logic [BAUD_W-1:0]    full_m1_s;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (i_Pclk),
    .reset (i_Reset),
    .d     (i_Rx_Serial),
    .q     (rx_s)
  );

`ifdef RXSHIFT_MAJORITY_EN
  logic rx_d1;
  logic rx_d2;

  // Keep the two previous line values for the 2-of-3 vote. The vote window
  // is the line delayed by one cycle, so the middle vote sits on the nominal
  // sample point and the decision lands one cycle after it.
  always_ff @(posedge i_Pclk) begin
    if (i_Reset) begin
      rx_d1 <= 1'b1;
      rx_d2 <= 1'b1;
    end else begin
      rx_d1 <= rx_s;
      rx_d2 <= rx_d1;
    end
  end

  assign sample_s = maj3(rx_d2, rx_d1, rx_s);
`else
  assign sample_s = rx_s;
`endif

  assign half_m1_s = (baud_q >> 1) - 14'd1;
  assign full_m1_s = baud_q - 14'd1;

  // Receive state machine: start detection, bit-centre sampling and delivery.
  always_ff @(posedge i_Pclk) begin
    if (i_Reset) begin
      state       <= s_IDLE;
      clock_count <= 14'd0;
      baud_q      <= 14'd0;
      bit_index   <= 3'd0;
      shift_q     <= 8'd0;
      data_q      <= 8'd0;
      pready_q    <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      armed_q     <= 1'b1;
    end else begin
      pready_q <= 1'b0;
      case (state)
        s_IDLE: begin
          if (rx_s) begin
            armed_q <= 1'b1;
          end else if (i_Enable && armed_q) begin
            state       <= s_START;
            clock_count <= 14'd0;
            baud_q      <= i_Baud;
            bit_index   <= 3'd0;
            busy_q      <= 1'b1;
          end else begin
            state <= s_IDLE;
          end
        end
        s_START: begin
          if (clock_count == half_m1_s) begin
            clock_count <= 14'd0;
            if (sample_s) begin
              state  <= s_IDLE;
              busy_q <= 1'b0;
            end else begin
              state <= s_DATA;
            end
          end else begin
            clock_count <= clock_count + 14'd1;
          end
        end
        s_DATA: begin
          if (clock_count == full_m1_s) begin
            clock_count        <= 14'd0;
            shift_q[bit_index] <= sample_s;
            if (bit_index == LAST_BIT) begin
              bit_index <= 3'd0;
              state     <= s_STOP;
            end else begin
              bit_index <= bit_index + 3'd1;
            end
          end else begin
            clock_count <= clock_count + 14'd1;
          end
        end
        s_STOP: begin
          if (clock_count == full_m1_s) begin
            clock_count <= 14'd0;
            data_q      <= shift_q;
            frame_err_q <= ~sample_s;
            pready_q    <= 1'b1;
            armed_q     <= sample_s;
            state       <= s_FINISH;
          end else begin
            clock_count <= clock_count + 14'd1;
          end
        end
        s_FINISH: begin
          state  <= s_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state       <= s_IDLE;
          clock_count <= 14'd0;
          bit_index   <= 3'd0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign o_Data      = data_q;
  assign o_Pready    = pready_q;
  assign o_Frame_Err = frame_err_q;
  assign o_Busy      = busy_q;

endmodule
